// File: rtl/scan_decoder_if.sv
// Bus between the control sequencer and scan_decoder: control strobes,
// select code and dwell in; one-hot select lines and scan status out.
interface scan_decoder_if #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 4
);
  localparam int N = 2 ** SEL_W;

  logic               selbar;
  logic               clr;
  logic               load;
  logic               mode;
  logic [0:SEL_W-1]   dec;
  logic [DWELL_W-1:0] dwell;
  logic [0:N-1]       a;
  logic [0:SEL_W-1]   idx;
  logic               busy;
  logic               done;

  modport master (
    output selbar, clr, load, mode, dec, dwell,
    input  a, idx, busy, done
  );

  modport slave (
    input  selbar, clr, load, mode, dec, dwell,
    output a, idx, busy, done
  );
endinterface

// File: rtl/scan_decoder.sv
// Registered binary-to-one-hot decoder with held direct select and auto-scan.
// Define SCAN_DECODER_TRISTATE_EN to float `a` while selbar is high.
module scan_decoder #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 4
) (
  input logic           clk,
  input logic           rst,
  scan_decoder_if.slave bus
);
  localparam int N = 2 ** SEL_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [0:N-1]       a_int, a_int_nxt;
  logic [0:SEL_W-1]   idx, idx_nxt;
  logic [0:SEL_W-1]   start, start_nxt;
  logic [DWELL_W-1:0] dwell_r, dwell_r_nxt;
  logic [DWELL_W-1:0] cnt, cnt_nxt;
  logic               busy, busy_nxt;
  logic               done, done_nxt;

  function automatic logic [0:N-1] onehot(input logic [0:SEL_W-1] code);
    onehot = {{(N-1){1'b0}}, 1'b1} << code;
  endfunction

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_int   <= {N{1'b0}};
      idx     <= {SEL_W{1'b0}};
      start   <= {SEL_W{1'b0}};
      dwell_r <= {DWELL_W{1'b0}};
      cnt     <= {DWELL_W{1'b0}};
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      a_int   <= a_int_nxt;
      idx     <= idx_nxt;
      start   <= start_nxt;
      dwell_r <= dwell_r_nxt;
      cnt     <= cnt_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

  // Next-state and datapath update; clr outranks load
  always_comb begin
    state_nxt   = state;
    a_int_nxt   = a_int;
    idx_nxt     = idx;
    start_nxt   = start;
    dwell_r_nxt = dwell_r;
    cnt_nxt     = cnt;
    done_nxt    = 1'b0;

    if (bus.clr) begin
      state_nxt = IDLE;
      a_int_nxt = {N{1'b0}};
      idx_nxt   = {SEL_W{1'b0}};
      cnt_nxt   = {DWELL_W{1'b0}};
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (bus.load) begin
            idx_nxt   = bus.dec;
            a_int_nxt = onehot(bus.dec);
            if (bus.mode) begin
              state_nxt   = SCAN;
              start_nxt   = bus.dec;
              dwell_r_nxt = bus.dwell;
              cnt_nxt     = bus.dwell;
            end else begin
              state_nxt = HOLD;
            end
          end else begin
            state_nxt = state;
          end
        end
        SCAN: begin
          if (cnt != {DWELL_W{1'b0}}) begin
            cnt_nxt = cnt - {{(DWELL_W-1){1'b0}}, 1'b1};
          end else if (idx == start - {{(SEL_W-1){1'b0}}, 1'b1}) begin
            // Last index of the pass: idx is left on the final code
            state_nxt = IDLE;
            a_int_nxt = {N{1'b0}};
            done_nxt  = 1'b1;
          end else begin
            idx_nxt   = idx + {{(SEL_W-1){1'b0}}, 1'b1};
            a_int_nxt = onehot(idx + {{(SEL_W-1){1'b0}}, 1'b1});
            cnt_nxt   = dwell_r;
          end
        end
        default: begin
          state_nxt = IDLE;
          a_int_nxt = {N{1'b0}};
        end
      endcase
    end

    busy_nxt = (state_nxt == SCAN);
  end

`ifdef SCAN_DECODER_TRISTATE_EN
  assign bus.a = bus.selbar ? {N{1'bz}} : a_int;
`else
  assign bus.a = bus.selbar ? {N{1'b0}} : a_int;
`endif

  assign bus.idx  = idx;
  assign bus.busy = busy;
  assign bus.done = done;
endmodule

// File: doc/scan_decoder.md
# scan_decoder

Parametrised, registered binary-to-one-hot decoder. It extends the team's 3-bit tristate decoder with four additions: configurable select width, a held direct-select mode, an auto-scan mode that walks every output with a programmable dwell, and busy/done status. It sits between the control sequencer and the select lines of a shared bus, where each one-hot output enables one bus client. The output stage is gated by the active-low `selbar` enable.

## Interface
Parameters:
- `SEL_W`, default 3. Select code width; output count N = 2**SEL_W.
- `DWELL_W`, default 4. Width of the dwell count.

Ports:
- `clk`  in  1  Sole clock, rising edge.
- `rst`  in  1  Reset, asynchronous, active-high.
- `selbar`  in  1  Output enable, active-low. Gates only the output stage, never the FSM.
- `clr`  in  1  Synchronous clear to IDLE.
- `load`  in  1  Start strobe, single cycle.
- `mode`  in  1  Sampled with `load`. 0 = direct, 1 = scan.
- `dec`  in  [0:SEL_W-1]  Select code. `dec[0]` is the MSB.
- `dwell`  in  DWELL_W  Extra cycles spent per scan index. Sampled with `load`.
- `a`  out  [0:N-1]  One-hot output. `a[0]` is the MSB, so `a` = 1 << code numerically; code 7 drives `a[0]`, code 0 drives `a[7]`.
- `idx`  out  [0:SEL_W-1]  Code currently decoded.
- `busy`  out  1  High while in SCAN.
- `done`  out  1  One-cycle pulse at scan completion.

## Operation
- Internal registers: `state`, `a_int`, `idx`, `start`, `dwell_r`, `cnt`.
- FSM states:
  - **IDLE**: `a_int` = 0.
  - **HOLD**: direct select is being held.
  - **SCAN**: auto-scan in progress.
- Priority order: `rst` > `clr` > `load`.
- `clr` in any state:
  - Next state IDLE; `a_int`, `idx` and `cnt` are cleared.
  - No `done` pulse.
- IDLE or HOLD with `load` and `mode`=0:
  - `idx` <= `dec`; `a_int` <= 1 << `dec`.
  - Next state HOLD.
  - In HOLD, a further `load` recaptures the code.
- IDLE or HOLD with `load` and `mode`=1:
  - `idx` and `start` <= `dec`; `dwell_r` and `cnt` <= `dwell`.
  - `a_int` <= 1 << `dec`.
  - Next state SCAN.
- SCAN behaviour:
  - Each cycle: if `cnt` != 0, `cnt` decrements.
  - Otherwise `idx` advances by 1 modulo N (N-1 wraps to 0), and `cnt` reloads from `dwell_r`.
  - Each index is held for `dwell_r`+1 cycles. A full pass is N×(`dwell_r`+1) cycles.
  - When `cnt`=0 and `idx` = (`start`-1) mod N, the pass ends:
    - next state IDLE, `a_int` <= 0, `done` <= 1 for one cycle;
    - `idx` keeps its last value.
  - `load` is ignored in SCAN.
- `busy` = (state == SCAN), registered.
- Output stage:
  - `selbar`=0: `a` = `a_int`.
  - `selbar`=1: behaviour per Configuration.

## Timing
- Reset values: state IDLE, `a_int`=0, `idx`=0, `cnt`=0, `busy`=0, `done`=0. `a` = 0, or high-Z if tristated.
- Reset takes effect immediately on assertion, including mid-scan. The first `load` is accepted on the first rising edge after `rst` deasserts.
- `load` sampled at edge k: `a`, `idx` and `busy` are valid after edge k (one-cycle latency).
- `done` rises on the same edge that clears `a_int` and `busy`.
- `selbar` is combinational to `a`, with zero latency.

## Configuration
- `SCAN_DECODER_TRISTATE_EN` defined: `selbar`=1 drives every bit of `a` to high-Z, matching the existing shared-bus decoder.
- Macro undefined: `selbar`=1 drives `a` to all zeros. No tristate is inferred; this build is for on-chip muxed buses.
- All other behaviour is identical in both builds.

## Test plan
All scenarios use SEL_W=3, DWELL_W=4, `selbar`=0 unless stated.
- **Reset:** `rst`=1 → `a`=8'h00, `busy`=0, `done`=0, `idx`=0. With `SCAN_DECODER_TRISTATE_EN` and `selbar`=1 → `a`=8'hzz.
- **Direct select:** `mode`=0, `load`, `dec`=3'b110 → `a`=8'h40 (`a[1]`) from the next cycle, held indefinitely; `busy`=0. A `clr` pulse → `a`=8'h00.
- **Scan with wrap:** `mode`=1, `load`, `dec`=3'b101, `dwell`=1.
  - `a` sequence, two cycles each: 20, 40, 80, 01, 02, 04, 08, 10 (16 cycles), `busy`=1 throughout.
  - Then `a`=00, `busy`=0, and a one-cycle `done`.
- **Output gating mid-scan:** toggle `selbar`=1 for 3 cycles during the 0x40 dwell → `a`=z or 0 during those cycles; the `idx` progression and the `done` cycle are unchanged from the previous case.
- **Simultaneous events:** `clr` and `load` asserted together during SCAN → IDLE, `a`=00, no `done`. `load` alone during SCAN → ignored.
- **Async reset mid-scan:** assert `rst` between clock edges → `a`=00 and `busy`=0 before the next edge, with no `done`.
